// File: rtl/sprite_raster_walker_pkg.sv
// Shared constants for the sprite raster walker: drawing modes, FSM state
// encodings, visible screen size and the transparent colour index.
package sprite_raster_walker_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] TRANSP = 3'b101;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_FILL   = 2'd0;  // solid fill_color
  localparam mode_t MODE_SPRITE = 2'd1;  // ROM data, TRANSP index skipped
  localparam mode_t MODE_OPAQUE = 2'd2;  // ROM data, every pixel drawn

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SCAN    = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;
  localparam logic [1:0] ST_DONE_ST = 2'd3;

endpackage

// File: rtl/sprite_raster_walker_if.sv
// Request, sprite-ROM and VGA plot signals of the raster walker.
// The ROM is sampled at the end of the cycle that presents rom_addr, so the
// colour of a pixel reaches the plot stream one cycle after its address.
interface sprite_raster_walker_if #(
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int SZ_W    = 6,
  parameter int ADDR_W  = 12,
  parameter int COLOR_W = 3
);
  logic               start;
  logic [1:0]         mode;
  logic [X_W-1:0]     x0;
  logic [Y_W-1:0]     y0;
  logic [SZ_W-1:0]    w;
  logic [SZ_W-1:0]    h;
  logic [COLOR_W-1:0] fill_color;
  logic               hold;
  logic [ADDR_W-1:0]  rom_addr;
  logic [COLOR_W-1:0] rom_data;
  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;
  logic [COLOR_W-1:0] colour;
  logic               plot;
  logic               busy;
  logic               done;

  modport master (
    output start, mode, x0, y0, w, h, fill_color, hold, rom_data,
    input  rom_addr, x, y, colour, plot, busy, done
  );

  modport slave (
    input  start, mode, x0, y0, w, h, fill_color, hold, rom_data,
    output rom_addr, x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/sprite_raster_walker_rect_counter.sv
// Row-major column/row walker with a running ROM address (row*w + col built
// by +1 per pixel). Stops on the last pixel; clear restarts at the origin.
module sprite_raster_walker_rect_counter #(
  parameter int SZ_W   = 6,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear,
  input  logic              step,
  input  logic [SZ_W-1:0]   w,
  input  logic [SZ_W-1:0]   h,
  output logic [SZ_W-1:0]   col,
  output logic [SZ_W-1:0]   row,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [SZ_W-1:0]   col_q, col_d;
  logic [SZ_W-1:0]   row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              row_end;

  assign row_end = (col_q == w - 1'b1);
  assign last    = row_end && (row_q == h - 1'b1);

  // Next position: restart on clear, otherwise advance one pixel per step.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    if (clear) begin
      col_d  = '0;
      row_d  = '0;
      addr_d = '0;
    end else if (step && !last) begin
      addr_d = addr_q + 1'b1;
      if (row_end) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      addr_q <= addr_d;
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign addr = addr_q;

endmodule

// File: rtl/sprite_raster_walker.sv
// Rectangle scanner for the VGA drawing path. A start pulse latches origin,
// size, mode and fill colour; the walker then fetches every pixel row-major
// and emits a registered (x, y, colour, plot) stream with clipping and
// transparency. hold stalls the whole pipeline and masks plot.
module sprite_raster_walker #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SCREEN_W = sprite_raster_walker_pkg::SCREEN_W,
  parameter int SCREEN_H = sprite_raster_walker_pkg::SCREEN_H,
  parameter int SZ_W     = 6,
  parameter int ADDR_W   = 12,
  parameter int COLOR_W  = 3,
  parameter logic [COLOR_W-1:0] TRANSP = sprite_raster_walker_pkg::TRANSP
) (
  input logic                   clk,
  input logic                   resetn,
  sprite_raster_walker_if.slave bus
);
  import sprite_raster_walker_pkg::*;

  // Sums carry two spare bits so an off-screen origin plus offset can never
  // wrap back onto the visible area.
  localparam int XS_W = X_W + 2;
  localparam int YS_W = Y_W + 2;
  typedef logic [XS_W-1:0] xs_t;
  typedef logic [YS_W-1:0] ys_t;
  localparam xs_t X_LIM = xs_t'(SCREEN_W);
  localparam ys_t Y_LIM = ys_t'(SCREEN_H);

  logic [1:0]         state_q, state_d;
  mode_t              mode_q, mode_d;
  logic [X_W-1:0]     x0_q, x0_d;
  logic [Y_W-1:0]     y0_q, y0_d;
  logic [SZ_W-1:0]    w_q, w_d;
  logic [SZ_W-1:0]    h_q, h_d;
  logic [COLOR_W-1:0] fill_q, fill_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic [COLOR_W-1:0] colour_q, colour_d;
  logic               plot_q, plot_d;

  logic               accept, rect_empty, adv, fetching, last;
  logic [SZ_W-1:0]    col, row;
  logic [ADDR_W-1:0]  addr;
  xs_t                xs;
  ys_t                ys;
  logic [COLOR_W-1:0] pix_colour;
  logic               clipped, transparent;

  assign accept     = bus.start && (state_q == ST_IDLE);
  assign rect_empty = (bus.w == '0) || (bus.h == '0);
  assign adv        = !bus.hold;
  assign fetching   = (state_q == ST_SCAN);

  sprite_raster_walker_rect_counter #(
    .SZ_W   (SZ_W),
    .ADDR_W (ADDR_W)
  ) u_rect_counter (
    .clk    (clk),
    .resetn (resetn),
    .clear  (accept && !rect_empty),
    .step   (adv && fetching),
    .w      (w_q),
    .h      (h_q),
    .col    (col),
    .row    (row),
    .addr   (addr),
    .last   (last)
  );

  // Request parameters are captured only on accept.
  always_comb begin
    mode_d = mode_q;
    x0_d   = x0_q;
    y0_d   = y0_q;
    w_d    = w_q;
    h_d    = h_q;
    fill_d = fill_q;
    if (accept) begin
      mode_d = bus.mode;
      x0_d   = bus.x0;
      y0_d   = bus.y0;
      w_d    = bus.w;
      h_d    = bus.h;
      fill_d = bus.fill_color;
    end
  end

  // Sequencing: an empty rectangle skips straight to the done cycle; DRAIN
  // lets the last fetched pixel leave the output stage.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (bus.start) state_d = rect_empty ? ST_DONE_ST : ST_SCAN;
      ST_SCAN:    if (adv && last) state_d = ST_DRAIN;
      ST_DRAIN:   if (adv) state_d = ST_DONE_ST;
      ST_DONE_ST: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  assign xs          = xs_t'(x0_q) + xs_t'(col);
  assign ys          = ys_t'(y0_q) + ys_t'(row);
  assign pix_colour  = (mode_q == MODE_FILL) ? fill_q : bus.rom_data;
  assign clipped     = (xs >= X_LIM) || (ys >= Y_LIM);
  assign transparent = (mode_q == MODE_SPRITE) && (pix_colour == TRANSP);

  // Output stage: register the fetched pixel; clipped and transparent pixels
  // still take their slot but do not strobe plot.
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = plot_q;
    if (adv) begin
      plot_d = fetching && !clipped && !transparent;
      if (fetching) begin
        x_d      = xs[X_W-1:0];
        y_d      = ys[Y_W-1:0];
        colour_d = pix_colour;
      end
    end
  end

  // State, latched request and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_FILL;
      x0_q     <= '0;
      y0_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      fill_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      w_q      <= w_d;
      h_q      <= h_d;
      fill_q   <= fill_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
    end
  end

  assign bus.rom_addr = addr;
  assign bus.x        = x_q;
  assign bus.y        = y_q;
  assign bus.colour   = colour_q;
  assign bus.plot     = plot_q && !bus.hold;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = (state_q == ST_DONE_ST);

endmodule

// File: tb/tb_sprite_raster_walker.sv
// Scoreboard bench for sprite_raster_walker: every rectangle pushes its
// expected plotted pixels; a negedge monitor pops and compares each plot.
module tb_sprite_raster_walker;

  localparam logic [1:0] M_FILL   = 2'd0;
  localparam logic [1:0] M_SPRITE = 2'd1;
  localparam logic [1:0] M_OPAQUE = 2'd2;

  logic clk;
  logic resetn;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  logic [17:0] sb[$];
  int plot_cnt, done_cnt, busy_cycles, first_plot_cyc, last_plot_cyc, done_cyc;
  int start_cyc;

  sprite_raster_walker_if bus_if ();

  sprite_raster_walker dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Sprite ROM: address as data, with only address 5 holding the transparent index.
  function automatic logic [2:0] rom_fn(input logic [11:0] a);
    if (a == 12'd5) return 3'b101;
    if (a[2:0] == 3'b101) return 3'b000;
    return a[2:0];
  endfunction

  assign bus_if.rom_data = rom_fn(bus_if.rom_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr_stats();
    plot_cnt = 0; done_cnt = 0; busy_cycles = 0;
    first_plot_cyc = -1; last_plot_cyc = -1; done_cyc = -1;
  endtask

  task automatic push_rect(input int x0, input int y0, input int w, input int h,
                           input logic [1:0] mode, input logic [2:0] fill);
    int xs, ys;
    logic [11:0] a;
    logic [2:0] c;
    for (int r = 0; r < h; r++) begin
      for (int k = 0; k < w; k++) begin
        xs = x0 + k;
        ys = y0 + r;
        a  = 12'(r * w + k);
        c  = (mode == M_FILL) ? fill : rom_fn(a);
        if (xs < 160 && ys < 120 && !(mode == M_SPRITE && c == 3'b101))
          sb.push_back({xs[7:0], ys[6:0], c});
      end
    end
  endtask

  task automatic go(input int x0, input int y0, input int w, input int h,
                    input logic [1:0] mode, input logic [2:0] fill);
    @(posedge clk); #1;
    bus_if.x0 = 8'(x0);
    bus_if.y0 = 7'(y0);
    bus_if.w = 6'(w);
    bus_if.h = 6'(h);
    bus_if.mode = mode;
    bus_if.fill_color = fill;
    bus_if.start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!bus_if.done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, bus_if.done, 1);
    @(posedge clk); #1;
  endtask

  // Plot monitor and scoreboard consumer.
  always @(negedge clk) begin
    if (resetn) begin
      if (bus_if.busy) busy_cycles++;
      if (bus_if.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus_if.hold) chk("hold_plot", bus_if.plot, 0);
      if (bus_if.plot) begin
        plot_cnt++;
        if (first_plot_cyc < 0) first_plot_cyc = cyc;
        last_plot_cyc = cyc;
        chk("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0)
          chk("pixel", {bus_if.x, bus_if.y, bus_if.colour}, sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0;
    bus_if.start = 1'b0; bus_if.hold = 1'b0; bus_if.mode = 2'd0;
    bus_if.x0 = '0; bus_if.y0 = '0; bus_if.w = '0; bus_if.h = '0;
    bus_if.fill_color = '0;
    clr_stats();
    #17;
    chk("rst_addr", bus_if.rom_addr, 0);
    chk("rst_x", bus_if.x, 0);
    chk("rst_y", bus_if.y, 0);
    chk("rst_colour", bus_if.colour, 0);
    chk("rst_plot", bus_if.plot, 0);
    chk("rst_busy", bus_if.busy, 0);
    chk("rst_done", bus_if.done, 0);
    @(negedge clk) resetn = 1'b1;

    // FILL 3x2
    clr_stats();
    push_rect(10, 20, 3, 2, M_FILL, 3'b010);
    go(10, 20, 3, 2, M_FILL, 3'b010);
    @(negedge clk);
    chk("fill_busy", bus_if.busy, 1);
    chk("fill_fetch_noplot", bus_if.plot, 0);
    wait_done("fill_done", 100);
    chk("fill_plots", plot_cnt, 6);
    chk("fill_latency", first_plot_cyc - start_cyc, 2);
    chk("fill_done_after_last", done_cyc - last_plot_cyc, 1);
    chk("fill_sb_empty", sb.size(), 0);

    // SPRITE 4x4 with one transparent pixel, address order checked per cycle
    clr_stats();
    push_rect(40, 30, 4, 4, M_SPRITE, 3'b000);
    go(40, 30, 4, 4, M_SPRITE, 3'b000);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("spr_addr", bus_if.rom_addr, k);
    end
    wait_done("spr_done", 100);
    chk("spr_plots", plot_cnt, 15);
    chk("spr_sb_empty", sb.size(), 0);

    clr_stats();
    push_rect(40, 30, 4, 4, M_OPAQUE, 3'b000);
    go(40, 30, 4, 4, M_OPAQUE, 3'b000);
    wait_done("opq_done", 100);
    chk("opq_plots", plot_cnt, 16);
    chk("opq_sb_empty", sb.size(), 0);

    // Clipping at the bottom-right corner
    clr_stats();
    push_rect(158, 118, 4, 4, M_FILL, 3'b110);
    go(158, 118, 4, 4, M_FILL, 3'b110);
    wait_done("clip_done", 100);
    chk("clip_plots", plot_cnt, 4);
    chk("clip_busy_cycles", busy_cycles, 18);
    chk("clip_done_cnt", done_cnt, 1);
    chk("clip_sb_empty", sb.size(), 0);

    // hold for three cycles mid-row
    clr_stats();
    push_rect(50, 60, 6, 2, M_OPAQUE, 3'b000);
    go(50, 60, 6, 2, M_OPAQUE, 3'b000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus_if.hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_addr", bus_if.rom_addr, 2);
      chk("hold_x", bus_if.x, 51);
      chk("hold_y", bus_if.y, 60);
      chk("hold_colour", bus_if.colour, rom_fn(12'd1));
    end
    @(posedge clk); #1;
    bus_if.hold = 1'b0;
    wait_done("hold_done", 100);
    chk("hold_plots", plot_cnt, 12);
    chk("hold_sb_empty", sb.size(), 0);

    // start while busy is ignored
    clr_stats();
    push_rect(20, 20, 4, 3, M_FILL, 3'b001);
    go(20, 20, 4, 3, M_FILL, 3'b001);
    @(posedge clk); #1;
    bus_if.x0 = 8'd90;
    bus_if.start = 1'b1;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    wait_done("busy_done", 100);
    chk("busy_plots", plot_cnt, 12);
    chk("busy_sb_empty", sb.size(), 0);

    // empty rectangle
    clr_stats();
    go(5, 5, 0, 3, M_FILL, 3'b111);
    @(negedge clk);
    chk("zero_done", bus_if.done, 1);
    chk("zero_addr", bus_if.rom_addr, 11);
    repeat (3) @(negedge clk);
    chk("zero_plots", plot_cnt, 0);
    chk("zero_done_cnt", done_cnt, 1);
    chk("zero_idle", bus_if.busy, 0);

    // asynchronous reset at pixel 5 of 16
    clr_stats();
    push_rect(30, 30, 4, 4, M_FILL, 3'b011);
    go(30, 30, 4, 4, M_FILL, 3'b011);
    repeat (5) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    chk("arst_addr", bus_if.rom_addr, 0);
    chk("arst_x", bus_if.x, 0);
    chk("arst_y", bus_if.y, 0);
    chk("arst_colour", bus_if.colour, 0);
    chk("arst_plot", bus_if.plot, 0);
    chk("arst_busy", bus_if.busy, 0);
    chk("arst_done", bus_if.done, 0);
    sb.delete();
    clr_stats();
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    repeat (4) @(negedge clk);
    chk("arst_no_done", done_cnt, 0);
    chk("arst_idle", bus_if.busy, 0);

    clr_stats();
    push_rect(30, 30, 4, 4, M_FILL, 3'b011);
    go(30, 30, 4, 4, M_FILL, 3'b011);
    wait_done("rescan_done", 100);
    chk("rescan_plots", plot_cnt, 16);
    chk("rescan_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
